sm4_round_ctrl: RTL and testbench

- Iterative sequencer for the registered SM4 round stage F_function. It accepts one 128-bit block with an encrypt/decrypt opcode and drives the round stage for 32 consecutive cycles.
- On each cycle it feeds the stage's outputs back to its inputs and supplies the round-key index to the key store.
- After the last round it applies the final reverse transform and presents the result through a valid/ready handshake.
- Sits between the top-level block interface and F_function plus the round-key memory.

---
 rtl/sm4_pkg.sv | 14 +
 rtl/sm4_round_ctrl_if.sv | 20 ++
 rtl/sm4_round_ctrl.sv | 117 +++++++++++
 tb/tb_sm4_round_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 constants: round count, sequencer state encoding and opcode values.
package sm4_pkg;
    localparam int SM4_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic OP_ENC = 1'b1;
    localparam logic OP_DEC = 1'b0;
endpackage

// File: rtl/sm4_round_ctrl_if.sv
// Block-level valid/ready bus between the block source/sink and the SM4 round sequencer.
interface sm4_round_ctrl_if;
    logic          in_valid;
    logic          in_ready;
    logic          in_opcode;
    logic [0:127]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [0:127]  out_data;

    modport master (
        output in_valid, in_opcode, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_opcode, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 sequencer: feeds the registered round stage for ROUNDS cycles, result valid 33 cycles after accept.
// Result is held until out_ready; no new block is accepted until it is taken.
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int ROUNDS = SM4_ROUNDS
) (
    input  logic          C_clk,
    input  logic          C_rst,
    input  logic          key_ready,
    sm4_round_ctrl_if.slave blk,
    output logic          err,
    output logic [0:4]    rk_addr,
    input  logic [0:31]   rk_in,
    output logic          F_begin,
    output logic          F_opcode,
    output logic [0:31]   F_rk1,
    output logic [0:31]   F_rk2,
    output logic [0:5]    F_count_in,
    output logic [0:31]   F_din0,
    output logic [0:31]   F_din1,
    output logic [0:31]   F_din2,
    output logic [0:31]   F_din3,
    input  logic [0:31]   F_dout0,
    input  logic [0:31]   F_dout1,
    input  logic [0:31]   F_dout2,
    input  logic [0:31]   F_dout3,
    input  logic [0:5]    F_count_out
);
    state_t        r_state;
    logic [4:0]    r_rnd;
    logic          r_mode;
    logic [0:127]  r_blk;
    logic          r_out_valid;
    logic [0:127]  r_out_data;
    logic          r_err;
    logic          w_in_ready;
    logic          w_run;
    logic          w_last;

    assign w_run      = (r_state == RUN);
    assign w_last     = (r_rnd == 5'(ROUNDS - 1));
    assign w_in_ready = (r_state == IDLE) && key_ready && !C_rst;

    assign blk.in_ready  = w_in_ready;
    assign blk.out_valid = r_out_valid;
    assign blk.out_data  = r_out_data;
    assign err           = r_err;

    assign F_begin    = w_run;
    assign F_opcode   = r_mode;
    assign F_rk1      = rk_in;
    assign F_rk2      = rk_in;
    assign F_count_in = {1'b0, r_rnd};

    // Round 0 takes the latched block; every later round chains the stage output straight back.
    always_comb begin
        F_din0  = '0;
        F_din1  = '0;
        F_din2  = '0;
        F_din3  = '0;
        rk_addr = '0;
        if (w_run) begin
            if (r_rnd == 5'd0) begin
                {F_din0, F_din1, F_din2, F_din3} = r_blk;
            end else begin
                {F_din0, F_din1, F_din2, F_din3} = {F_dout0, F_dout1, F_dout2, F_dout3};
            end
            rk_addr = (r_mode == OP_ENC) ? r_rnd : 5'(ROUNDS - 1) - r_rnd;
        end
    end

    always_ff @(posedge C_clk) begin
        if (C_rst) begin
            r_state     <= IDLE;
            r_rnd       <= '0;
            r_mode      <= 1'b0;
            r_blk       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (blk.in_valid && w_in_ready) begin
                        r_blk   <= blk.in_data;
                        r_mode  <= blk.in_opcode;
                        r_rnd   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_rnd <= r_rnd + 5'd1;
                    if (w_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Stage output still holds round 31 here; word order reversal is the final transform.
                    r_out_data  <= {F_dout3, F_dout2, F_dout1, F_dout0};
                    r_out_valid <= 1'b1;
                    if (F_count_out != 6'(ROUNDS)) begin
                        r_err <= 1'b1;
                    end
                    r_state <= OUT;
                end
                OUT: begin
                    if (blk.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Bench for sm4_round_ctrl: behavioural round stage and rk ROM, scoreboard against a whole-block SM4 model.
module tb_sm4_round_ctrl;
    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    typedef logic [31:0][31:0] rk_pk_t;
    typedef struct {
        logic [127:0] exp;
        logic         enc;
        int           acc;
        logic         err;
    } item_t;

    logic         C_clk = 1'b0;
    logic         C_rst;
    logic         key_ready;
    logic         err;
    logic [0:4]   rk_addr;
    logic [0:31]  rk_in;
    logic         F_begin, F_opcode;
    logic [0:31]  F_rk1, F_rk2;
    logic [0:5]   F_count_in, F_count_out;
    logic [0:31]  F_din0, F_din1, F_din2, F_din3;
    logic [0:31]  F_dout0, F_dout1, F_dout2, F_dout3;

    sm4_round_ctrl_if bus ();

    sm4_round_ctrl #(.ROUNDS(32)) dut (
        .C_clk(C_clk), .C_rst(C_rst), .key_ready(key_ready), .blk(bus), .err(err),
        .rk_addr(rk_addr), .rk_in(rk_in), .F_begin(F_begin), .F_opcode(F_opcode),
        .F_rk1(F_rk1), .F_rk2(F_rk2), .F_count_in(F_count_in),
        .F_din0(F_din0), .F_din1(F_din1), .F_din2(F_din2), .F_din3(F_din3),
        .F_dout0(F_dout0), .F_dout1(F_dout1), .F_dout2(F_dout2), .F_dout3(F_dout3),
        .F_count_out(F_count_out)
    );

    always #5 C_clk = ~C_clk;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    item_t  sb_q[$];
    bit     seen = 0;
    logic [127:0] first_dat;
    logic   force_cnt = 1'b0;
    logic   err_model = 1'b0;
    rk_pk_t rk_rom;
    logic [127:0] cur_key;

    always @(posedge C_clk) cyc <= cyc + 1;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    function automatic rk_pk_t expand_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        rk_pk_t rk;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk[i]  = k[i+4];
        end
        return rk;
    endfunction

    function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] d, input logic enc);
        logic [31:0] x [36];
        rk_pk_t rk;
        rk = expand_key(key);
        x[0] = d[127:96]; x[1] = d[95:64]; x[2] = d[63:32]; x[3] = d[31:0];
        for (int i = 0; i < 32; i++)
            x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ (enc ? rk[i] : rk[31-i]));
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Behavioural registered round stage and combinational key ROM.
    logic [31:0] st_d0 = '0, st_d1 = '0, st_d2 = '0, st_d3 = '0;
    logic [5:0]  st_cnt = '0;
    always @(posedge C_clk) begin
        if (F_begin) begin
            st_d0  <= F_din1;
            st_d1  <= F_din2;
            st_d2  <= F_din3;
            st_d3  <= F_din0 ^ t_enc(F_din1 ^ F_din2 ^ F_din3 ^ (F_opcode ? F_rk1 : F_rk2));
            st_cnt <= F_count_in + 6'd1;
        end
    end
    assign F_dout0 = st_d0;
    assign F_dout1 = st_d1;
    assign F_dout2 = st_d2;
    assign F_dout3 = st_d3;
    assign F_count_out = force_cnt ? 6'd31 : st_cnt;
    assign rk_in = rk_rom[rk_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: rk_addr order during rounds, latency, hold under stall, result and err at handshake.
    always begin
        logic [4:0] ea;
        int k;
        @(negedge C_clk);
        #2;
        if (!C_rst) begin
            if (F_begin) begin
                if (sb_q.size() == 0) fail_now("unexpected_run");
                else begin
                    k  = cyc - sb_q[0].acc;
                    ea = sb_q[0].enc ? 5'(k) : 5'(31 - k);
                    check("rk_addr", rk_addr, ea);
                end
            end
            if (bus.out_valid) begin
                if (sb_q.size() == 0) fail_now("unexpected_out_valid");
                else begin
                    if (!seen) begin
                        check("latency", cyc, sb_q[0].acc + 33);
                        seen = 1;
                        first_dat = bus.out_data;
                    end else begin
                        check("out_hold", bus.out_data, first_dat);
                    end
                    check("in_ready_in_out", bus.in_ready, 0);
                    if (bus.out_ready) begin
                        check("out_data", bus.out_data, sb_q[0].exp);
                        check("err", err, sb_q[0].err);
                        void'(sb_q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic enc, input logic [127:0] exp, output int waited);
        item_t it;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_opcode = enc;
        waited = 0;
        forever begin
            #1;
            if (bus.in_ready || waited >= 200) break;
            @(negedge C_clk);
            waited++;
        end
        if (bus.in_ready) begin
            it.exp = exp;
            it.enc = enc;
            it.acc = cyc + 1;
            it.err = err_model | force_cnt;
            sb_q.push_back(it);
        end else begin
            fail_now("accept_timeout");
        end
        @(negedge C_clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < budget) begin
            @(negedge C_clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            fail_now("result_timeout");
            sb_q.delete();
            seen = 0;
        end
    endtask

    initial begin
        int w;
        int t;
        logic [127:0] d;
        logic enc;
        C_rst = 1'b1;
        key_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_opcode = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        cur_key = PT;
        rk_rom = expand_key(cur_key);

        repeat (2) @(negedge C_clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_F_begin", F_begin, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_rk_addr", rk_addr, 0);
        @(negedge C_clk);
        C_rst = 1'b0;
        #1 check("idle_no_key_in_ready", bus.in_ready, 0);
        @(negedge C_clk);
        key_ready = 1'b1;
        #1 check("idle_key_in_ready", bus.in_ready, 1);
        @(negedge C_clk);

        // Standard vector both ways with the same key schedule.
        send(PT, 1'b1, CT, w);
        wait_done(100);
        send(CT, 1'b0, PT, w);
        wait_done(100);

        // Back-pressure: result held, second block offered but refused until handshake.
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b0;
        send(d, 1'b1, sm4_ref(cur_key, d, 1'b1), w);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge C_clk);
            t++;
        end
        check("bp_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b1;
        bus.in_data = PT;
        bus.in_opcode = 1'b1;
        repeat (10) begin
            #1 check("bp_in_ready", bus.in_ready, 0);
            @(negedge C_clk);
        end
        bus.out_ready = 1'b1;
        send(PT, 1'b1, CT, w);
        check("bp_accept_after_handshake", w, 1);
        wait_done(100);

        // Key gating.
        key_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = CT;
        bus.in_opcode = 1'b0;
        repeat (5) begin
            #1 check("gate_in_ready", bus.in_ready, 0);
            @(negedge C_clk);
        end
        key_ready = 1'b1;
        send(CT, 1'b0, PT, w);
        check("gate_accept_same_edge", w, 0);
        wait_done(100);

        // Reset at round 15.
        send(PT, 1'b1, CT, w);
        repeat (15) @(negedge C_clk);
        C_rst = 1'b1;
        @(negedge C_clk);
        #1;
        check("midrst_F_begin", F_begin, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        sb_q.delete();
        seen = 0;
        err_model = 1'b0;
        C_rst = 1'b0;
        #1 check("midrst_idle", bus.in_ready, 1);
        @(negedge C_clk);
        send(PT, 1'b1, CT, w);
        wait_done(100);

        // Round-count mismatch is sticky across a good block until reset.
        force_cnt = 1'b1;
        send(PT, 1'b1, CT, w);
        wait_done(100);
        force_cnt = 1'b0;
        err_model = 1'b1;
        send(CT, 1'b0, PT, w);
        wait_done(100);
        #1 check("err_sticky", err, 1);
        C_rst = 1'b1;
        @(negedge C_clk);
        #1 check("err_cleared", err, 0);
        C_rst = 1'b0;
        err_model = 1'b0;
        @(negedge C_clk);

        // Random keys, blocks, opcodes and consumer stalls.
        for (int b = 0; b < 6; b++) begin
            cur_key = {$urandom, $urandom, $urandom, $urandom};
            rk_rom = expand_key(cur_key);
            d = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom_range(0, 1));
            send(d, enc, sm4_ref(cur_key, d, enc), w);
            t = 0;
            while (sb_q.size() != 0 && t < 300) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge C_clk);
                t++;
            end
            bus.out_ready = 1'b1;
            wait_done(100);
        end

        repeat (3) @(negedge C_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
